// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential non-restoring divider.
package div_pkg;
    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DIV_WIDTH);
endpackage

// File: rtl/nrd_addsub.sv
// W-bit controlled add/subtract array: control=1 computes a + ~b + cin, control=0 a + b + cin.
module nrd_addsub #(
    parameter int W = 17
) (
    input  logic         control,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] result,
    output logic         cout
);
    logic [W-1:0] bx;

    assign bx = control ? ~b : b;
    assign {cout, result} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
endmodule

// File: rtl/nonrestoring_div_seq.sv
// Sequential non-restoring divider, one quotient bit per clock.
// Build with DIV_SIGNED_EN defined to add the div_signed port and two's-complement mode.
module nonrestoring_div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             div_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state, nstate;
    logic [WIDTH:0]   p, dr, p_sh, as_a, sum;
    logic [WIDTH-1:0] aq, n_abs, d_abs, q_fix, r_mag, r_fix;
    logic [CW-1:0]    cnt;
    logic             as_ctl, as_cin, unused_cout;
    logic             accept, last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (cnt == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
    logic n_neg, d_neg, sq, sr;
    assign n_neg = div_signed & dividend[WIDTH-1];
    assign d_neg = div_signed & divisor[WIDTH-1];
    assign n_abs = n_neg ? -dividend : dividend;
    assign d_abs = d_neg ? -divisor  : divisor;
`else
    assign n_abs = dividend;
    assign d_abs = divisor;
`endif

    // CALC shifts {P,Aq} before the add/sub; FIX reuses the array for the correction add.
    assign p_sh = {p[WIDTH-1:0], aq[WIDTH-1]};

    always_comb begin
        as_a   = p_sh;
        as_ctl = ~p[WIDTH];
        as_cin = ~p[WIDTH];
        if (state == FIX) begin
            as_a   = p;
            as_ctl = 1'b0;
            as_cin = 1'b0;
        end
    end

    nrd_addsub #(.W(WIDTH + 1)) u_addsub (
        .control (as_ctl),
        .a       (as_a),
        .b       (dr),
        .cin     (as_cin),
        .result  (sum),
        .cout    (unused_cout)
    );

    assign r_mag = p[WIDTH] ? sum[WIDTH-1:0] : p[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    assign q_fix = sq ? -aq : aq;
    assign r_fix = sr ? -r_mag : r_mag;
`else
    assign q_fix = aq;
    assign r_fix = r_mag;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate    = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nstate = (divisor == '0) ? DONE : CALC;
            end
            CALC: if (last_step) nstate = FIX;
            FIX:  nstate = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p         <= '0;
            aq        <= '0;
            dr        <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
            sq        <= 1'b0;
            sr        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    p   <= '0;
                    aq  <= n_abs;
                    dr  <= {1'b0, d_abs};
                    cnt <= '0;
`ifdef DIV_SIGNED_EN
                    sq  <= n_neg ^ d_neg;
                    sr  <= n_neg;
`endif
                    if (divisor == '0) begin
                        quotient  <= '1;
                        remainder <= dividend;
                        div_zero  <= 1'b1;
                    end else begin
                        div_zero  <= 1'b0;
                    end
                end
                CALC: begin
                    p   <= sum;
                    aq  <= {aq[WIDTH-2:0], ~sum[WIDTH]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nonrestoring_div_seq.sv
// Randomised self-checking bench for nonrestoring_div_seq against an arithmetic reference.
module tb_nonrestoring_div_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         div_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nonrestoring_div_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef DIV_SIGNED_EN
        .div_signed (div_signed),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_zero   (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division from the arithmetic rules.
    task automatic ref_div(input logic [W-1:0] n, input logic [W-1:0] d, input logic sg,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        int sn, sd;
        if (d == 0) begin
            q = '1;
            r = n;
        end else if (!sg) begin
            q = W'(int'(n) / int'(d));
            r = W'(int'(n) % int'(d));
        end else begin
            sn = int'($signed(n));
            sd = int'($signed(d));
            q = W'(sn / sd);
            r = W'(sn % sd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one division and waits for out_valid; lat counts edges from the accept edge.
    task automatic do_div(input logic [W-1:0] n, input logic [W-1:0] d, input logic sg,
                          output int lat);
        int t = 0;
        while (!in_ready && t < 200) begin tick(); t++; end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        dividend   = n;
        divisor    = d;
        div_signed = sg;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic sg);
        logic [W-1:0] eq, er;
        int lat;
        ref_div(n, d, sg, eq, er);
        do_div(n, d, sg, lat);
        chk({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
        chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, d == 0});
        chk({tag, "_lat"}, lat, (d == 0) ? 1 : W + 2);
        tick();
    endtask

    initial begin
        logic [W-1:0] n, d, hq, hr;
        int lat;

        #12;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient",  {16'd0, quotient},  32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_div_zero",  {31'd0, div_zero},  32'd0);
        rst = 1'b0;
        tick();

        run("t1_100_7", 16'd100, 16'd7, 1'b0);
        chk("t1_q_const", {16'd0, quotient}, 32'd14);
        run("t2_ffff_1", 16'hFFFF, 16'd1, 1'b0);
        run("t2_5_9", 16'd5, 16'd9, 1'b0);
        chk("t2_r_const", {16'd0, remainder}, 32'd5);
        run("t3_dz", 16'd1234, 16'd0, 1'b0);
        run("t3_after_dz", 16'd65000, 16'd255, 1'b0);

        // Backpressure in DONE with a competing request on the input side.
        out_ready = 1'b0;
        do_div(16'd1000, 16'd33, 1'b0, lat);
        hq = quotient;
        hr = remainder;
        chk("t4_q", {16'd0, hq}, 32'd30);
        chk("t4_r", {16'd0, hr}, 32'd10);
        dividend = 16'd77;
        divisor  = 16'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_ready", {31'd0, in_ready}, 32'd0);
            chk("t4_hold_q", {16'd0, quotient}, {16'd0, hq});
            chk("t4_hold_r", {16'd0, remainder}, {16'd0, hr});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t4_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_idle_q", {16'd0, quotient}, {16'd0, hq});

        // Reset in the middle of CALC.
        dividend = 16'd50000;
        divisor  = 16'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) begin
            tick();
            chk("t5_no_output", {31'd0, out_valid}, 32'd0);
        end
        run("t5_81_9", 16'd81, 16'd9, 1'b0);

`ifdef DIV_SIGNED_EN
        run("t6_m7_2", 16'hFFF9, 16'd2, 1'b1);
        chk("t6_q_const", {16'd0, quotient}, 32'h0000FFFD);
        run("t6_min_m1", 16'h8000, 16'hFFFF, 1'b1);
        chk("t6_min_q_const", {16'd0, quotient}, 32'h00008000);
        run("t6_dz", 16'hFF00, 16'd0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            n = W'($urandom);
            d = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            run("rnd_s", n, d, 1'b1);
        end
`endif

        // Random unsigned scoreboard with the division identity checked as well.
        for (int i = 0; i < 3000; i++) begin
            n = W'($urandom);
            case ($urandom_range(0, 3))
                0:       d = W'($urandom_range(0, 15));
                1:       d = W'($urandom_range(0, 255));
                default: d = W'($urandom);
            endcase
            run("rnd_u", n, d, 1'b0);
            if (d != 0) begin
                chk("rnd_u_ident", int'(quotient) * int'(d) + int'(remainder), int'(n));
                chk("rnd_u_rltd", {31'd0, remainder < d}, 32'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
